// File: rtl/linear_ccd_timing.sv
// Timing generator for a linear CCD: shift-gate pulse, phi/rs/sp readout clocks,
// ADC strobe with effective-pixel qualification, and optional extra integration.
module linear_ccd_timing #(
  parameter int PIXELS      = 5340,
  parameter int DUMMY_LEAD  = 64,
  parameter int DUMMY_TRAIL = 14,
  parameter int PHI_DIV     = 10,
  parameter int SH_WIDTH    = 100,
  parameter int INT_W       = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [INT_W-1:0] int_time,
  output logic             phi,
  output logic             sh,
  output logic             rs,
  output logic             sp,
  output logic             adc_strobe,
  output logic             pix_valid,
  output logic [15:0]      pix_idx,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int PER = 2 * PHI_DIV;
  localparam int NPER = DUMMY_LEAD + PIXELS + DUMMY_TRAIL;
  localparam int PHW = $clog2(PER);
  localparam int CW = (INT_W > 16) ? INT_W : 16;

  localparam logic [PHW-1:0] PH_LAST   = PHW'(PER - 1);
  localparam logic [PHW-1:0] PH_HALF   = PHW'(PHI_DIV);
  localparam logic [PHW-1:0] PH_QTR    = PHW'(PHI_DIV / 2);
  localparam logic [PHW-1:0] PH_SP_END = PHW'(PHI_DIV + PHI_DIV / 2);
  localparam logic [PHW-1:0] PH_ADC    = PHW'(PHI_DIV + PHI_DIV / 2 - 1);
  localparam logic [CW-1:0]  SH_LAST   = CW'(SH_WIDTH - 1);
  localparam logic [CW-1:0]  PER_LAST  = CW'(NPER - 1);
  localparam logic [CW-1:0]  PIX_LO    = CW'(DUMMY_LEAD);
  localparam logic [CW-1:0]  PIX_HI    = CW'(DUMMY_LEAD + PIXELS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SH,
    S_READOUT,
    S_INTEGRATE
  } state_t;

  state_t           state_q, state_d;
  logic [PHW-1:0]   ph_q, ph_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [INT_W-1:0] int_lat_q, int_lat_d;
  logic             end_frame;

  logic        phi_q, phi_d;
  logic        sh_q, sh_d;
  logic        rs_q, rs_d;
  logic        sp_q, sp_d;
  logic        adc_q, adc_d;
  logic        pv_q, pv_d;
  logic [15:0] idx_q, idx_d;
  logic        fs_q, fs_d;
  logic        fd_q, fd_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    int_lat_d = int_lat_q;
    fs_d      = 1'b0;
    fd_d      = 1'b0;
    end_frame = 1'b0;

    // cnt counts sh cycles in S_SH and whole phi periods in READOUT/INTEGRATE
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SH;
          cnt_d     = '0;
          fs_d      = 1'b1;
          int_lat_d = int_time;
        end
      end
      S_SH: begin
        if (cnt_q == SH_LAST) begin
          state_d = S_READOUT;
          ph_d    = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READOUT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (cnt_q == PER_LAST) begin
            fd_d  = 1'b1;
            cnt_d = '0;
            if (int_lat_q != '0) state_d = S_INTEGRATE;
            else end_frame = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_INTEGRATE: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (cnt_q == CW'(int_lat_q) - CW'(1)) end_frame = 1'b1;
          else cnt_d = cnt_q + 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_frame) begin
      cnt_d = '0;
      ph_d  = '0;
      if (cont) begin
        state_d   = S_SH;
        fs_d      = 1'b1;
        int_lat_d = int_time;
      end else begin
        state_d = S_IDLE;
      end
    end

    // Outputs are decoded from next-state values so the registered copies line up with state
    sh_d   = (state_d == S_SH);
    phi_d  = sh_d || (((state_d == S_READOUT) || (state_d == S_INTEGRATE)) && (ph_d < PH_HALF));
    rs_d   = (state_d == S_READOUT) && (ph_d < PH_QTR);
    sp_d   = (state_d == S_READOUT) && (ph_d >= PH_HALF) && (ph_d < PH_SP_END);
    adc_d  = (state_d == S_READOUT) && (ph_d == PH_ADC);
    pv_d   = adc_d && (cnt_d >= PIX_LO) && (cnt_d < PIX_HI);
    idx_d  = pv_d ? 16'(cnt_d - PIX_LO) : idx_q;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      cnt_q     <= '0;
      int_lat_q <= '0;
      phi_q     <= 1'b0;
      sh_q      <= 1'b0;
      rs_q      <= 1'b0;
      sp_q      <= 1'b0;
      adc_q     <= 1'b0;
      pv_q      <= 1'b0;
      idx_q     <= '0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      int_lat_q <= int_lat_d;
      phi_q     <= phi_d;
      sh_q      <= sh_d;
      rs_q      <= rs_d;
      sp_q      <= sp_d;
      adc_q     <= adc_d;
      pv_q      <= pv_d;
      idx_q     <= idx_d;
      fs_q      <= fs_d;
      fd_q      <= fd_d;
      busy_q    <= busy_d;
    end
  end

  assign phi         = phi_q;
  assign sh          = sh_q;
  assign rs          = rs_q;
  assign sp          = sp_q;
  assign adc_strobe  = adc_q;
  assign pix_valid   = pv_q;
  assign pix_idx     = idx_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign busy        = busy_q;

endmodule

// File: doc/linear_ccd_timing.md
LINEAR_CCD_TIMING -- requirements
Module: linear_ccd_timing

Interface
REQ-001 SHALL have parameter PIXELS, 5340, effective pixels per frame.
REQ-002 SHALL have parameter DUMMY_LEAD, 64, dummy pixels read before the effective pixels.
REQ-003 SHALL have parameter DUMMY_TRAIL, 14, dummy pixels read after the effective pixels.
REQ-004 SHALL have parameter PHI_DIV, 10, clk cycles per phi half-period (even, >=2).
REQ-005 SHALL have parameter SH_WIDTH, 100, clk cycles of the sh pulse (>=1).
REQ-006 SHALL have parameter INT_W, 24, integration-time width.
REQ-007 SHALL have port clk  in  1  clock; one clock; all logic on rising edge.
REQ-008 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-009 SHALL have port start  in  1  single-frame request, sampled in IDLE.
REQ-010 SHALL have port cont  in  1  continuous mode; sampled at frame end.
REQ-011 SHALL have port int_time  in  INT_W  extra integration, in phi periods; latched at frame_start.
REQ-012 SHALL have ports phi, sh, rs, sp  out  1 each  CCD clock, shift gate, reset gate, sample pulse.
REQ-013 SHALL have port adc_strobe  out  1  one-cycle ADC conversion strobe, every readout period.
REQ-014 SHALL have port pix_valid  out  1  adc_strobe qualified to effective pixels only.
REQ-015 SHALL have port pix_idx  out  16  effective pixel index, valid with pix_valid.
REQ-016 SHALL have ports frame_start, frame_done, busy  out  1 each  one-cycle pulses / activity flag.

Function
REQ-017 SHALL implement states IDLE, SH, READOUT, INTEGRATE; all outputs registered.
REQ-018 IDLE: start=1 at cycle T -> cycle T+1 enters SH; frame_start=1, busy=1, sh=1, phi=1 for one cycle (frame_start) / SH_WIDTH cycles (sh, phi).
REQ-019 SH: after SH_WIDTH cycles -> READOUT at cycle R=T+SH_WIDTH+1; sh=0 from R.
REQ-020 READOUT: N=DUMMY_LEAD+PIXELS+DUMMY_TRAIL periods of 2*PHI_DIV cycles; phase ph=0..2*PHI_DIV-1, ph=0 at R.
REQ-021 Per period: phi=1 for ph<PHI_DIV else 0; rs=1 for ph<PHI_DIV/2; sp=1 for PHI_DIV<=ph<PHI_DIV+PHI_DIV/2.
REQ-022 adc_strobe=1 at ph=PHI_DIV+PHI_DIV/2-1 of every READOUT period, including dummy periods.
REQ-023 pix_valid=1 with adc_strobe for periods k in [DUMMY_LEAD, DUMMY_LEAD+PIXELS-1]; pix_idx=k-DUMMY_LEAD, held otherwise.
REQ-024 frame_done=1 for one cycle at R+N*2*PHI_DIV (first cycle after READOUT).
REQ-025 INTEGRATE: phi keeps toggling per REQ-021, rs=sp=adc_strobe=0, lasts latched int_time*2*PHI_DIV cycles; int_time=0 skips INTEGRATE.
REQ-026 End of frame (end of INTEGRATE, or end of READOUT if skipped): cont=1 -> SH (new frame_start same cycle as frame_done when skipped); cont=0 -> IDLE, busy=0, phi=0.
REQ-027 start while busy SHALL be ignored; cont deasserted mid-frame SHALL complete the current frame.
REQ-028 int_time changes mid-frame SHALL NOT affect the current frame.
REQ-029 No phi glitch: phi changes at most once per PHI_DIV cycles outside state transitions into/out of IDLE.

Reset
REQ-030 rst=1 at any cycle SHALL, next cycle, force IDLE, all outputs 0, pix_idx=0, counters cleared, mid-frame included.
REQ-031 start/cont held during rst SHALL have no effect until the cycle after rst deasserts.

Verification (PIXELS=8, DUMMY_LEAD=2, DUMMY_TRAIL=1, PHI_DIV=4, SH_WIDTH=6, start at cycle 0)
REQ-032 int_time=0, cont=0 -> frame_start at 1, sh 1..6, R=7, first adc_strobe 12, pix_idx 0 valid at 28, pix_idx 7 at 84, frame_done and busy=0 at 95.
REQ-033 Same, int_time=3 -> INTEGRATE cycles 95..118, phi toggling, frame_done at 95, busy=0 at 119.
REQ-034 cont=1, int_time=0 -> frame_done and second frame_start both at 95, 16 pix_valid pulses over two frames, idx 0..7 each.
REQ-035 start pulsed again at cycle 40 -> ignored; exactly 8 pix_valid pulses, single frame_start.
REQ-036 rst asserted at cycle 50 -> cycle 51 all outputs 0, IDLE; start at 60 -> frame_start at 61.
